bmp_draw_sched: RTL and testbench
=================================

BMP_DRAW_SCHED -- requirements
Module: bmp_draw_sched

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO depth; power of 2, range 2..16.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents a command.
REQ-005 reqN_ready  output  1  requester N command accepted this cycle.
REQ-006 reqN_op  input  2  operation code: 00 add image, 01 remove image, 10 add font glyph, 11 reserved.
REQ-007 reqN_indx  input  6  index: image index in [4:0], font index 0..41 in [5:0].
REQ-008 reqN_x  input  10  x location; reqN_y  input  9  y location.
REQ-009 eng_idle  input  1  placement engine is in its idle state.
REQ-010 add_img, rem_img, add_fnt  output  1 each  one-cycle launch strobes to the engine.
REQ-011 image_indx  output  5; fnt_indx  output  6; xloc  output  10; yloc  output  9.
REQ-012 busy  output  1  scheduler not in IDLE, or FIFO non-empty.
REQ-013 cmd_cnt  output  5  current FIFO occupancy.

Function
REQ-014 Arbitration SHALL be round-robin between the two requesters, with at most one acceptance per cycle.
REQ-015 If only one requester is valid, that requester SHALL be granted.
REQ-016 If both requesters are valid, the requester other than the last-accepted one SHALL be granted.
REQ-017 The round-robin pointer SHALL update only on an acceptance.
REQ-018 reqN_ready SHALL equal grant_N AND NOT full, where full is the registered condition cmd_cnt==DEPTH.
REQ-019 An acceptance is valid AND ready; the command is enqueued on that clock edge.
REQ-020 A command with op 11 SHALL be accepted (ready asserted) but discarded, not enqueued.
REQ-021 The FIFO SHALL be first-in-first-out, storing {op, indx, x, y}, 27 bits.
REQ-022 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-023 An enqueue and a dequeue in the same cycle SHALL leave cmd_cnt unchanged.
REQ-024 FSM states: IDLE, ISSUE, SETTLE, WAIT.
REQ-025 IDLE: if the FIFO is non-empty AND eng_idle=1, dequeue the head into the output registers and go to ISSUE; otherwise stay in IDLE.
REQ-026 ISSUE: assert exactly one strobe for one cycle per the dequeued op (00 -> add_img, 01 -> rem_img, 10 -> add_fnt); go to SETTLE.
REQ-027 SETTLE: hold one cycle so the engine leaves idle; go to WAIT.
REQ-028 WAIT: stay until eng_idle=1, then go to IDLE.
REQ-029 Minimum spacing between strobes SHALL be 4 cycles: ISSUE, SETTLE, WAIT (1 cycle minimum), IDLE.
REQ-030 image_indx, fnt_indx, xloc and yloc SHALL be registered, become valid in ISSUE, and stay stable until the next dequeue.
REQ-031 image_indx SHALL be indx[4:0]; fnt_indx SHALL be indx[5:0].
REQ-032 Strobes SHALL be registered outputs and SHALL be mutually exclusive.
REQ-033 busy SHALL be combinational from the state and cmd_cnt.
REQ-034 eng_idle=0 in IDLE SHALL block dequeue indefinitely; enqueue SHALL continue meanwhile.

Reset
REQ-035 On rst_n low, asynchronously: state=IDLE; FIFO empty; cmd_cnt=0; round-robin pointer favours requester 0.
REQ-036 On rst_n low, asynchronously: all strobes=0; image_indx, fnt_indx, xloc, yloc=0; busy=0.
REQ-037 Reset mid-command SHALL discard all queued and in-flight commands; no strobe SHALL be asserted in the cycle after rst_n deasserts.

Verification
REQ-038 Single command: req0 op=00, indx=1, x=100, y=50, eng_idle=1 -> add_img pulses exactly once, 2 cycles after acceptance, with xloc=100, yloc=50, image_indx=1.
REQ-039 Contention: both requesters valid for 4 cycles, distinct commands -> accepts alternate 0,1,0,1 and strobes issue in that same order.
REQ-040 Full: DEPTH=4, eng_idle held 0, 5 commands offered on req0 -> 4 accepted, cmd_cnt=4, ready low on the 5th; raising eng_idle drains all 4 in order.
REQ-041 Reserved op: req1 op=11 -> ready=1, cmd_cnt stays 0, no strobe.
REQ-042 Engine wait: eng_idle forced 0 for 20 cycles after SETTLE -> no second strobe until eng_idle returns to 1.
REQ-043 Reset in WAIT with 3 commands queued -> cmd_cnt=0, busy=0, no strobes afterwards.

Source files
------------

// File: rtl/bmp_draw_sched_if.sv
// Requester, engine and status signals of the bitmap draw scheduler.
// The scheduler takes the slave modport; requesters/engine side takes master.
interface bmp_draw_sched_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [5:0] req0_indx;
  logic [9:0] req0_x;
  logic [8:0] req0_y;

  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [5:0] req1_indx;
  logic [9:0] req1_x;
  logic [8:0] req1_y;

  logic       eng_idle;
  logic       add_img;
  logic       rem_img;
  logic       add_fnt;
  logic [4:0] image_indx;
  logic [5:0] fnt_indx;
  logic [9:0] xloc;
  logic [8:0] yloc;
  logic       busy;
  logic [4:0] cmd_cnt;

  modport master (
    output req0_valid, req0_op, req0_indx, req0_x, req0_y,
    output req1_valid, req1_op, req1_indx, req1_x, req1_y,
    output eng_idle,
    input  req0_ready, req1_ready,
    input  add_img, rem_img, add_fnt, image_indx, fnt_indx, xloc, yloc,
    input  busy, cmd_cnt
  );

  modport slave (
    input  req0_valid, req0_op, req0_indx, req0_x, req0_y,
    input  req1_valid, req1_op, req1_indx, req1_x, req1_y,
    input  eng_idle,
    output req0_ready, req1_ready,
    output add_img, rem_img, add_fnt, image_indx, fnt_indx, xloc, yloc,
    output busy, cmd_cnt
  );
endinterface

// File: rtl/bmp_draw_sched.sv
// Round-robin command scheduler for the bitmap placement engine: two requesters
// feed a FIFO that is issued one command at a time as launch strobes.
module bmp_draw_sched #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bmp_draw_sched_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  logic [1:0]    state;
  logic          last1;
  logic [26:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    cnt;

  logic          full;
  logic          empty;
  logic          grant0;
  logic          grant1;
  logic          acc0;
  logic          acc1;
  logic          enq;
  logic          deq;
  logic [26:0]   wdata;
  logic [26:0]   rdata;

  logic          add_img_q;
  logic          rem_img_q;
  logic          add_fnt_q;
  logic [4:0]    image_indx_q;
  logic [5:0]    fnt_indx_q;
  logic [9:0]    xloc_q;
  logic [8:0]    yloc_q;

  // last1 set means requester 1 was accepted last, so requester 0 wins a tie
  always_comb begin
    full   = (cnt == DEPTH_CNT);
    empty  = (cnt == 5'd0);
    grant0 = bus.req0_valid & (~bus.req1_valid | last1);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last1);
    acc0   = grant0 & ~full;
    acc1   = grant1 & ~full;
    wdata  = acc1 ? {bus.req1_op, bus.req1_indx, bus.req1_x, bus.req1_y}
                  : {bus.req0_op, bus.req0_indx, bus.req0_x, bus.req0_y};
    // reserved op is handshaken but never stored
    enq    = (acc0 & (bus.req0_op != 2'b11)) | (acc1 & (bus.req1_op != 2'b11));
    deq    = (state == IDLE) & ~empty & bus.eng_idle;
    rdata  = mem[rd_ptr];
  end

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.add_img    = add_img_q;
  assign bus.rem_img    = rem_img_q;
  assign bus.add_fnt    = add_fnt_q;
  assign bus.image_indx = image_indx_q;
  assign bus.fnt_indx   = fnt_indx_q;
  assign bus.xloc       = xloc_q;
  assign bus.yloc       = yloc_q;
  assign bus.cmd_cnt    = cnt;
  assign bus.busy       = (state != IDLE) | ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1 <= 1'b1;
    end else if (acc0 | acc1) begin
      last1 <= acc1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Strobes are loaded at the dequeue edge so they are high only during ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      add_img_q    <= 1'b0;
      rem_img_q    <= 1'b0;
      add_fnt_q    <= 1'b0;
      image_indx_q <= '0;
      fnt_indx_q   <= '0;
      xloc_q       <= '0;
      yloc_q       <= '0;
    end else begin
      add_img_q <= 1'b0;
      rem_img_q <= 1'b0;
      add_fnt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (deq) begin
            state        <= ISSUE;
            add_img_q    <= (rdata[26:25] == 2'b00);
            rem_img_q    <= (rdata[26:25] == 2'b01);
            add_fnt_q    <= (rdata[26:25] == 2'b10);
            image_indx_q <= rdata[23:19];
            fnt_indx_q   <= rdata[24:19];
            xloc_q       <= rdata[18:9];
            yloc_q       <= rdata[8:0];
          end
        end
        ISSUE:   state <= SETTLE;
        SETTLE:  state <= WAIT;
        WAIT:    if (bus.eng_idle) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_draw_sched.sv
// Directed bench for bmp_draw_sched: each task drives one scenario and checks
// its expectations inline; a monitor logs every strobe with its cycle number.
module tb_bmp_draw_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bmp_draw_sched_if bus();

  bmp_draw_sched #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    int         kind;
    logic [4:0] img;
    logic [5:0] fnt;
    logic [9:0] x;
    logic [8:0] y;
  } strobe_t;

  strobe_t log_q[$];
  strobe_t ent;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.add_img | bus.rem_img | bus.add_fnt)) begin
      checks++;
      if (int'(bus.add_img) + int'(bus.rem_img) + int'(bus.add_fnt) != 1) begin
        errors++;
        $display("FAIL strobe_exclusive: add_img=%b rem_img=%b add_fnt=%b, required exactly one",
                 bus.add_img, bus.rem_img, bus.add_fnt);
      end
      ent.c    = cyc;
      ent.kind = bus.add_img ? 0 : (bus.rem_img ? 1 : 2);
      ent.img  = bus.image_indx;
      ent.fnt  = bus.fnt_indx;
      ent.x    = bus.xloc;
      ent.y    = bus.yloc;
      log_q.push_back(ent);
    end
  end

  task automatic drive0(input logic v, input logic [1:0] op, input logic [5:0] ix,
                        input logic [9:0] x, input logic [8:0] y);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_indx = ix; bus.req0_x = x; bus.req0_y = y;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op, input logic [5:0] ix,
                        input logic [9:0] x, input logic [8:0] y);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_indx = ix; bus.req1_x = x; bus.req1_y = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive0(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    drive1(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    bus.eng_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic wait_first_strobe(input string name);
    for (int t = 0; t < 12 && log_q.size() == 0; t++) @(negedge clk);
    checks++;
    if (log_q.size() == 0) begin
      errors++;
      $display("FAIL %s_timeout: no strobe within 12 cycles, required one", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive0(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    drive1(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    bus.eng_idle = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.cmd_cnt !== 5'd0) begin errors++; $display("FAIL reset_cmd_cnt: got %0d required 0", bus.cmd_cnt); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++;
    if ({bus.add_img, bus.rem_img, bus.add_fnt} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b required 000", {bus.add_img, bus.rem_img, bus.add_fnt});
    end
    checks++;
    if ({bus.image_indx, bus.fnt_indx, bus.xloc, bus.yloc} !== 30'd0) begin
      errors++; $display("FAIL reset_outputs: img=%0d fnt=%0d x=%0d y=%0d required all 0",
                         bus.image_indx, bus.fnt_indx, bus.xloc, bus.yloc);
    end
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b required 00", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int acc;
    do_reset();
    @(negedge clk);
    drive0(1'b1, 2'b00, 6'd1, 10'd100, 9'd50);
    #1;
    acc = cyc;
    checks++;
    if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", bus.req0_ready); end
    @(negedge clk);
    drive0(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    checks++;
    if (bus.cmd_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt: got %0d required 1", bus.cmd_cnt); end
    repeat (10) @(negedge clk);
    checks++;
    if (log_q.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d strobes required 1", log_q.size());
    end
    if (log_q.size() >= 1) begin
      checks++;
      if (log_q[0].kind != 0 || log_q[0].c != acc + 2) begin
        errors++; $display("FAIL single_strobe: kind %0d at +%0d, required add_img(0) at +2",
                           log_q[0].kind, log_q[0].c - acc);
      end
      checks++;
      if (log_q[0].x !== 10'd100 || log_q[0].y !== 9'd50 || log_q[0].img !== 5'd1) begin
        errors++; $display("FAIL single_fields: x=%0d y=%0d img=%0d required 100 50 1",
                           log_q[0].x, log_q[0].y, log_q[0].img);
      end
    end
    checks++;
    if (bus.xloc !== 10'd100 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_hold: xloc=%0d busy=%b required 100 0", bus.xloc, bus.busy);
    end
  endtask

  task automatic test_contention();
    logic [1:0] op0 [3] = '{2'b00, 2'b10, 2'b00};
    logic [5:0] ix0 [3] = '{6'd2, 6'd40, 6'd9};
    logic [9:0] x0  [3] = '{10'd10, 10'd30, 10'd99};
    logic [1:0] op1 [3] = '{2'b01, 2'b00, 2'b00};
    logic [5:0] ix1 [3] = '{6'd3, 6'd17, 6'd9};
    logic [9:0] x1  [3] = '{10'd11, 10'd31, 10'd99};
    int         ekind [4] = '{0, 1, 2, 0};
    logic [4:0] eimg  [4] = '{5'd2, 5'd3, 5'd8, 5'd17};
    logic [5:0] efnt  [4] = '{6'd2, 6'd3, 6'd40, 6'd17};
    logic [9:0] ex    [4] = '{10'd10, 10'd11, 10'd30, 10'd31};
    int i0 = 0;
    int i1 = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive0(1'b1, op0[i0], ix0[i0], x0[i0], 9'd20);
      drive1(1'b1, op1[i1], ix1[i1], x1[i1], 9'd21);
      #1;
      checks++;
      if (bus.req0_ready !== (k % 2 == 0) || bus.req1_ready !== (k % 2 == 1)) begin
        errors++; $display("FAIL contention_grant%0d: ready0=%b ready1=%b required %b %b",
                           k, bus.req0_ready, bus.req1_ready, (k % 2 == 0), (k % 2 == 1));
      end
      if (bus.req0_ready) i0++;
      if (bus.req1_ready) i1++;
    end
    @(negedge clk);
    drive0(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    drive1(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    repeat (30) @(negedge clk);
    checks++;
    if (log_q.size() != 4) begin
      errors++; $display("FAIL contention_count: got %0d strobes required 4", log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].kind != ekind[i] || log_q[i].img !== eimg[i] || log_q[i].fnt !== efnt[i] || log_q[i].x !== ex[i]) begin
        errors++; $display("FAIL contention_order%0d: kind=%0d img=%0d fnt=%0d x=%0d required %0d %0d %0d %0d",
                           i, log_q[i].kind, log_q[i].img, log_q[i].fnt, log_q[i].x,
                           ekind[i], eimg[i], efnt[i], ex[i]);
      end
      if (i > 0) begin
        checks++;
        if (log_q[i].c - log_q[i-1].c != 4) begin
          errors++; $display("FAIL contention_spacing%0d: got %0d cycles required 4", i, log_q[i].c - log_q[i-1].c);
        end
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.eng_idle = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive0(1'b1, 2'b00, 6'(k + 4), 10'(200 + k), 9'(k + 1));
      #1;
      checks++;
      if (bus.req0_ready !== (k < 4)) begin
        errors++; $display("FAIL full_ready%0d: got %b required %b", k, bus.req0_ready, (k < 4));
      end
    end
    @(negedge clk);
    drive0(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    checks++;
    if (bus.cmd_cnt !== 5'd4 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL full_cnt: cmd_cnt=%0d busy=%b required 4 1", bus.cmd_cnt, bus.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (log_q.size() != 0) begin errors++; $display("FAIL full_blocked: got %0d strobes required 0", log_q.size()); end
    bus.eng_idle = 1'b1;
    repeat (25) @(negedge clk);
    checks++;
    if (log_q.size() != 4 || bus.cmd_cnt !== 5'd0) begin
      errors++; $display("FAIL full_drain: got %0d strobes cmd_cnt=%0d required 4 0", log_q.size(), bus.cmd_cnt);
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].x !== 10'(200 + i) || log_q[i].img !== 5'(i + 4) || log_q[i].y !== 9'(i + 1)) begin
        errors++; $display("FAIL full_order%0d: x=%0d img=%0d y=%0d required %0d %0d %0d",
                           i, log_q[i].x, log_q[i].img, log_q[i].y, 200 + i, i + 4, i + 1);
      end
    end
  endtask

  task automatic test_reserved();
    do_reset();
    @(negedge clk);
    drive1(1'b1, 2'b11, 6'd5, 10'd7, 9'd9);
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL reserved_ready: got %b required 1", bus.req1_ready); end
    @(negedge clk);
    drive1(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    checks++;
    if (bus.cmd_cnt !== 5'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reserved_cnt: cmd_cnt=%0d busy=%b required 0 0", bus.cmd_cnt, bus.busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (log_q.size() != 0) begin errors++; $display("FAIL reserved_strobe: got %0d strobes required 0", log_q.size()); end
  endtask

  task automatic test_engine_wait();
    int r;
    do_reset();
    @(negedge clk);
    drive0(1'b1, 2'b00, 6'd6, 10'd50, 9'd60);
    @(negedge clk);
    drive0(1'b1, 2'b01, 6'd7, 10'd51, 9'd61);
    @(negedge clk);
    drive0(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    wait_first_strobe("engine_wait");
    bus.eng_idle = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != 1 || bus.cmd_cnt !== 5'd1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL engine_wait_hold: strobes=%0d cmd_cnt=%0d busy=%b required 1 1 1",
                         log_q.size(), bus.cmd_cnt, bus.busy);
    end
    bus.eng_idle = 1'b1;
    r = cyc;
    repeat (4) @(negedge clk);
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL engine_wait_resume: got %0d strobes required 2", log_q.size());
    end else if (log_q[1].c != r + 2 || log_q[1].kind != 1 || log_q[1].x !== 10'd51) begin
      errors++; $display("FAIL engine_wait_second: kind=%0d at +%0d x=%0d required rem_img(1) at +2 x=51",
                         log_q[1].kind, log_q[1].c - r, log_q[1].x);
    end
  endtask

  task automatic test_reset_wait();
    int n;
    do_reset();
    @(negedge clk);
    drive0(1'b1, 2'b00, 6'd1, 10'd1, 9'd1);
    @(negedge clk);
    drive0(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    wait_first_strobe("reset_wait");
    bus.eng_idle = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive0(1'b1, 2'b10, 6'(10 + k), 10'(300 + k), 9'd5);
    end
    @(negedge clk);
    drive0(1'b0, 2'b00, 6'd0, 10'd0, 9'd0);
    #1;
    checks++;
    if (bus.cmd_cnt !== 5'd3 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_wait_queued: cmd_cnt=%0d busy=%b required 3 1", bus.cmd_cnt, bus.busy);
    end
    n = log_q.size();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cmd_cnt !== 5'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_wait_async: cmd_cnt=%0d busy=%b required 0 0", bus.cmd_cnt, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.eng_idle = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (log_q.size() != n || bus.cmd_cnt !== 5'd0) begin
      errors++; $display("FAIL reset_wait_after: new strobes=%0d cmd_cnt=%0d required 0 0",
                         log_q.size() - n, bus.cmd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_reserved();
    test_engine_wait();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
